mbus_layer_msg_handler: RTL and testbench
=========================================

MBUS_LAYER_MSG_HANDLER -- requirements
Module: mbus_layer_msg_handler

Interface
REQ-001 SHALL have ports: CLK in 1, rising-edge clock; RESET in 1, synchronous active-high reset; one clock, reset is synchronous and active-high.
REQ-002 SHALL have RX ports: RX_ADDR in 32, message address; RX_DATA in 32, message word; RX_REQ in 1, word valid; RX_PEND in 1, more words follow; RX_BROADCAST in 1, broadcast message; RX_FAIL in 1, message aborted; RX_ACK out 1, word accepted.
REQ-003 SHALL have TX ports: TX_ADDR out 32, reply address; TX_DATA out 32, reply word; TX_REQ out 1, word request; TX_PEND out 1, more words follow; TX_PRIORITY out 1, always 0; TX_ACK in 1, word taken; TX_SUCC in 1, message succeeded; TX_FAIL in 1, message failed; TX_RESP_ACK out 1, result acknowledged.
REQ-004 SHALL have register-file ports: REG_WR_EN out 1, write strobe; REG_WR_ADDR out 8; REG_WR_DATA out 24; REG_RD_ADDR out 8; REG_RD_DATA in 24, valid one cycle after REG_RD_ADDR changes.
REQ-005 SHALL have status ports: MSG_CNT out 8, completed messages, wraps; TX_ERR out 1, one-cycle pulse on TX_FAIL.

Function
REQ-006 SHALL decode function ID RX_ADDR[3:0]: 0 = register write, 1 = register read, other = ignore (still handshaken); RX_BROADCAST=1 messages SHALL be ignored.
REQ-007 SHALL implement RX four-phase handshake: in IDLE/RX_DROP, latch RX_ADDR/RX_DATA on RX_REQ rising, assert RX_ACK next cycle, hold RX_ACK until RX_REQ low, drop RX_ACK the cycle after.
REQ-008 Register write: each word SHALL produce one-cycle REG_WR_EN with REG_WR_ADDR=RX_DATA[31:24], REG_WR_DATA=RX_DATA[23:0], in the cycle RX_ACK rises.
REQ-009 Register read: first word fields SHALL be start=[31:24], count-1=[23:16], reply short address=[15:8], reply function ID=[7:0]; later words of the same message SHALL be acked and discarded.
REQ-010 States SHALL be IDLE, RX_DROP, RD_FETCH, TX_WORD, TX_ACKLOW, TX_WAIT_RESP, TX_RESP; read starts RD_FETCH only after RX_REQ low with RX_PEND=0 on last word.
REQ-011 RD_FETCH SHALL drive REG_RD_ADDR, wait one cycle, capture REG_RD_DATA, go TX_WORD.
REQ-012 TX_WORD SHALL drive TX_ADDR={16'h0, reply addr, reply FID}, TX_DATA={reg addr, REG_RD_DATA}, TX_PEND=1 except last word, TX_REQ=1 until TX_ACK=1; then TX_REQ=0, go TX_ACKLOW.
REQ-013 TX_ACKLOW SHALL wait TX_ACK=0, then increment reg addr (8-bit wrap FF->00) and go RD_FETCH, or TX_WAIT_RESP after last word.
REQ-014 TX_WAIT_RESP SHALL wait TX_SUCC or TX_FAIL, then TX_RESP holds TX_RESP_ACK=1 until both low, then IDLE.
REQ-015 TX_FAIL seen in any TX state SHALL abort remaining words, pulse TX_ERR, go TX_RESP.
REQ-016 count-1=8'hFF SHALL transmit 256 words.
REQ-017 RX_FAIL=1 SHALL discard the message in progress, leave completed writes intact, not increment MSG_CNT, return IDLE after RX_REQ low.
REQ-018 RX_REQ arriving outside IDLE/RX_DROP SHALL not be acked until IDLE.
REQ-019 MSG_CNT SHALL increment by 1 once per completed write message (last word, RX_PEND=0) and per read reply ending in TX_SUCC.

Reset
REQ-020 RESET=1 at a clock edge SHALL force IDLE and all outputs 0 (RX_ACK, TX_REQ, TX_PEND, TX_RESP_ACK, REG_WR_EN, TX_ERR, MSG_CNT, addresses/data), including mid-transaction; no handshake completion is owed.

Verification
REQ-021 Write RX_ADDR=0x00000010, RX_DATA=0x05ABCDEF, RX_PEND=0 -> one REG_WR_EN, addr 0x05, data 0xABCDEF, RX_ACK until RX_REQ low, MSG_CNT=1.
REQ-022 Read word 0x02011403 -> 2 TX words, TX_ADDR=0x00001403, TX_DATA={0x02,reg2} pend 1 then {0x03,reg3} pend 0; TX_SUCC -> TX_RESP_ACK, MSG_CNT +1.
REQ-023 Read start 0xFF count-1 0x01 -> TX_DATA[31:24] 0xFF then 0x00.
REQ-024 TX_FAIL after first word of 3 -> no further TX_REQ, TX_ERR one cycle, TX_RESP_ACK, MSG_CNT unchanged.
REQ-025 3-word write with RX_FAIL on word 3 -> two writes done, MSG_CNT unchanged; RESET asserted during TX_WORD -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mbus_layer_msg_handler.sv
`default_nettype none
// ============================================================================
//  Module      : mbus_layer_msg_handler
//  Description : MBus layer message handler. Incoming messages can write
//                register-file words or request a register read-back. A
//                read-back is returned as a multi-word TX reply. Completed
//                messages are counted.
//  Revision    : 1.0  initial release
// ============================================================================
module mbus_layer_msg_handler (
    input  logic        CLK,
    input  logic        RESET,
    // RX message side
    input  logic [31:0] RX_ADDR,
    input  logic [31:0] RX_DATA,
    input  logic        RX_REQ,
    input  logic        RX_PEND,
    input  logic        RX_BROADCAST,
    input  logic        RX_FAIL,
    output logic        RX_ACK,
    // TX reply side
    output logic [31:0] TX_ADDR,
    output logic [31:0] TX_DATA,
    output logic        TX_REQ,
    output logic        TX_PEND,
    output logic        TX_PRIORITY,
    input  logic        TX_ACK,
    input  logic        TX_SUCC,
    input  logic        TX_FAIL,
    output logic        TX_RESP_ACK,
    // register file
    output logic        REG_WR_EN,
    output logic [7:0]  REG_WR_ADDR,
    output logic [23:0] REG_WR_DATA,
    output logic [7:0]  REG_RD_ADDR,
    input  logic [23:0] REG_RD_DATA,
    // status
    output logic [7:0]  MSG_CNT,
    output logic        TX_ERR
);

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_RX_DROP      = 3'd1,
        ST_RD_FETCH     = 3'd2,
        ST_TX_WORD      = 3'd3,
        ST_TX_ACKLOW    = 3'd4,
        ST_TX_WAIT_RESP = 3'd5,
        ST_TX_RESP      = 3'd6
    } state_t;

    localparam logic [1:0] MODE_IGNORE = 2'd0;
    localparam logic [1:0] MODE_WRITE  = 2'd1;
    localparam logic [1:0] MODE_READ   = 2'd2;

    state_t      state_q, state_d;

    logic        rx_ack_q;
    logic        pend_q;       // RX_PEND of the word being handshaken
    logic        rx_fail_q;    // current message was aborted by the sender
    logic        in_msg_q;     // a multi-word message is in progress
    logic [1:0]  mode_q;       // kind of the message in progress
    logic        reg_wr_en_q;
    logic [7:0]  reg_wr_addr_q;
    logic [23:0] reg_wr_data_q;
    logic [7:0]  addr_q;       // current read-back register address
    logic [7:0]  remain_q;     // words still to send after the current one
    logic [7:0]  reply_q;
    logic [7:0]  fid_q;
    logic [23:0] data_q;
    logic        fetch_wait_q;
    logic [7:0]  msg_cnt_q;
    logic        tx_err_q;

    logic        w_rx_state;
    logic        w_tx_state;
    logic        w_accept;
    logic        w_word_done;
    logic        w_rx_abort;
    logic        w_cnt_inc;
    logic [1:0]  w_mode_new;
    logic [1:0]  w_mode_now;
    logic        unused_rx_addr;

    assign w_rx_state  = (state_q == ST_IDLE) || (state_q == ST_RX_DROP);
    assign w_tx_state  = (state_q == ST_RD_FETCH) || (state_q == ST_TX_WORD) ||
                         (state_q == ST_TX_ACKLOW) || (state_q == ST_TX_WAIT_RESP);
    assign w_accept    = w_rx_state && RX_REQ && !rx_ack_q;
    assign w_word_done = rx_ack_q && !RX_REQ;
    // Sender gave up between words: drop the partial message.
    assign w_rx_abort  = w_rx_state && in_msg_q && RX_FAIL && !RX_REQ && !rx_ack_q;

    assign w_mode_new  = RX_BROADCAST          ? MODE_IGNORE :
                         (RX_ADDR[3:0] == 4'd0) ? MODE_WRITE  :
                         (RX_ADDR[3:0] == 4'd1) ? MODE_READ   : MODE_IGNORE;
    // Later words of a message inherit the kind decoded from the first word.
    assign w_mode_now  = in_msg_q ? mode_q : w_mode_new;

    assign w_cnt_inc   = (w_word_done && !pend_q && !rx_fail_q && (mode_q == MODE_WRITE)) ||
                         ((state_q == ST_TX_WAIT_RESP) && !TX_FAIL && TX_SUCC);

    assign unused_rx_addr = ^RX_ADDR[31:4];

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and TX handshake outputs.
    always_comb begin
        state_d     = state_q;
        TX_REQ      = 1'b0;
        TX_PEND     = 1'b0;
        TX_RESP_ACK = 1'b0;
        case (state_q)
            ST_IDLE, ST_RX_DROP: begin
                if (w_word_done) begin
                    if (rx_fail_q) begin
                        state_d = ST_IDLE;
                    end else if (pend_q) begin
                        state_d = (mode_q == MODE_WRITE) ? ST_IDLE : ST_RX_DROP;
                    end else begin
                        state_d = (mode_q == MODE_READ) ? ST_RD_FETCH : ST_IDLE;
                    end
                end else if (w_rx_abort) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_FETCH: begin
                if (TX_FAIL) begin
                    state_d = ST_TX_RESP;
                end else if (fetch_wait_q) begin
                    state_d = ST_TX_WORD;
                end
            end
            ST_TX_WORD: begin
                TX_REQ  = 1'b1;
                TX_PEND = (remain_q != 8'd0);
                if (TX_FAIL) begin
                    state_d = ST_TX_RESP;
                end else if (TX_ACK) begin
                    state_d = ST_TX_ACKLOW;
                end
            end
            ST_TX_ACKLOW: begin
                if (TX_FAIL) begin
                    state_d = ST_TX_RESP;
                end else if (!TX_ACK) begin
                    state_d = (remain_q == 8'd0) ? ST_TX_WAIT_RESP : ST_RD_FETCH;
                end
            end
            ST_TX_WAIT_RESP: begin
                if (TX_FAIL || TX_SUCC) begin
                    state_d = ST_TX_RESP;
                end
            end
            ST_TX_RESP: begin
                TX_RESP_ACK = 1'b1;
                if (!TX_SUCC && !TX_FAIL) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RX handshake, register-file access, read-back datapath and counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_ack_q      <= 1'b0;
            pend_q        <= 1'b0;
            rx_fail_q     <= 1'b0;
            in_msg_q      <= 1'b0;
            mode_q        <= MODE_IGNORE;
            reg_wr_en_q   <= 1'b0;
            reg_wr_addr_q <= 8'd0;
            reg_wr_data_q <= 24'd0;
            addr_q        <= 8'd0;
            remain_q      <= 8'd0;
            reply_q       <= 8'd0;
            fid_q         <= 8'd0;
            data_q        <= 24'd0;
            fetch_wait_q  <= 1'b0;
            msg_cnt_q     <= 8'd0;
            tx_err_q      <= 1'b0;
        end else begin
            reg_wr_en_q  <= 1'b0;
            tx_err_q     <= w_tx_state && TX_FAIL;
            fetch_wait_q <= (state_q == ST_RD_FETCH) && !fetch_wait_q;

            if (w_accept) begin
                rx_ack_q  <= 1'b1;
                pend_q    <= RX_PEND;
                rx_fail_q <= RX_FAIL;
                mode_q    <= w_mode_now;
                // The write strobe rises together with RX_ACK.
                if ((w_mode_now == MODE_WRITE) && !RX_FAIL) begin
                    reg_wr_en_q   <= 1'b1;
                    reg_wr_addr_q <= RX_DATA[31:24];
                    reg_wr_data_q <= RX_DATA[23:0];
                end
                // Only the first word of a read carries the request fields.
                if (!in_msg_q && (w_mode_now == MODE_READ)) begin
                    addr_q   <= RX_DATA[31:24];
                    remain_q <= RX_DATA[23:16];
                    reply_q  <= RX_DATA[15:8];
                    fid_q    <= RX_DATA[7:0];
                end
            end else if (rx_ack_q && RX_FAIL) begin
                rx_fail_q <= 1'b1;
            end

            if (w_word_done) begin
                rx_ack_q <= 1'b0;
                in_msg_q <= pend_q && !rx_fail_q;
            end else if (w_rx_abort) begin
                in_msg_q <= 1'b0;
            end

            if ((state_q == ST_RD_FETCH) && fetch_wait_q) begin
                data_q <= REG_RD_DATA;
            end

            // Step to the next register once the previous word is released.
            if ((state_q == ST_TX_ACKLOW) && !TX_FAIL && !TX_ACK && (remain_q != 8'd0)) begin
                remain_q <= remain_q - 8'd1;
                addr_q   <= addr_q + 8'd1;
            end

            if (w_cnt_inc) begin
                msg_cnt_q <= msg_cnt_q + 8'd1;
            end
        end
    end

    assign RX_ACK      = rx_ack_q;
    assign TX_ADDR     = {16'h0000, reply_q, fid_q};
    assign TX_DATA     = {addr_q, data_q};
    assign TX_PRIORITY = 1'b0;
    assign REG_WR_EN   = reg_wr_en_q;
    assign REG_WR_ADDR = reg_wr_addr_q;
    assign REG_WR_DATA = reg_wr_data_q;
    assign REG_RD_ADDR = addr_q;
    assign MSG_CNT     = msg_cnt_q;
    assign TX_ERR      = tx_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mbus_layer_msg_handler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mbus_layer_msg_handler
//  Description : Self-checking bench for mbus_layer_msg_handler: a table of
//                write/ignore messages plus directed read-back sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mbus_layer_msg_handler;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] RX_ADDR = '0;
    logic [31:0] RX_DATA = '0;
    logic        RX_REQ = 1'b0;
    logic        RX_PEND = 1'b0;
    logic        RX_BROADCAST = 1'b0;
    logic        RX_FAIL = 1'b0;
    logic        RX_ACK;
    logic [31:0] TX_ADDR;
    logic [31:0] TX_DATA;
    logic        TX_REQ;
    logic        TX_PEND;
    logic        TX_PRIORITY;
    logic        TX_ACK = 1'b0;
    logic        TX_SUCC = 1'b0;
    logic        TX_FAIL = 1'b0;
    logic        TX_RESP_ACK;
    logic        REG_WR_EN;
    logic [7:0]  REG_WR_ADDR;
    logic [23:0] REG_WR_DATA;
    logic [7:0]  REG_RD_ADDR;
    logic [23:0] REG_RD_DATA = '0;
    logic [7:0]  MSG_CNT;
    logic        TX_ERR;

    int total = 0;
    int bad   = 0;

    int          wr_cnt = 0;
    logic [7:0]  last_waddr = '0;
    logic [23:0] last_wdata = '0;
    int          ack_rises = 0;
    int          txreq_rises = 0;
    int          err_cycles = 0;
    logic        ack_prev = 1'b0;
    logic        txreq_prev = 1'b0;

    mbus_layer_msg_handler dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .RX_ADDR      (RX_ADDR),
        .RX_DATA      (RX_DATA),
        .RX_REQ       (RX_REQ),
        .RX_PEND      (RX_PEND),
        .RX_BROADCAST (RX_BROADCAST),
        .RX_FAIL      (RX_FAIL),
        .RX_ACK       (RX_ACK),
        .TX_ADDR      (TX_ADDR),
        .TX_DATA      (TX_DATA),
        .TX_REQ       (TX_REQ),
        .TX_PEND      (TX_PEND),
        .TX_PRIORITY  (TX_PRIORITY),
        .TX_ACK       (TX_ACK),
        .TX_SUCC      (TX_SUCC),
        .TX_FAIL      (TX_FAIL),
        .TX_RESP_ACK  (TX_RESP_ACK),
        .REG_WR_EN    (REG_WR_EN),
        .REG_WR_ADDR  (REG_WR_ADDR),
        .REG_WR_DATA  (REG_WR_DATA),
        .REG_RD_ADDR  (REG_RD_ADDR),
        .REG_RD_DATA  (REG_RD_DATA),
        .MSG_CNT      (MSG_CNT),
        .TX_ERR       (TX_ERR)
    );

    always #5 CLK = ~CLK;

    // Register-file contents as a fixed function of the address.
    function automatic logic [23:0] rom(input logic [7:0] a);
        return {a ^ 8'h3C, ~a, a};
    endfunction

    // Registered read port: data follows the address by one cycle.
    always @(posedge CLK) REG_RD_DATA <= rom(REG_RD_ADDR);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Observe strobes and edges between clock edges.
    always @(negedge CLK) begin
        if (REG_WR_EN) begin
            wr_cnt++;
            last_waddr = REG_WR_ADDR;
            last_wdata = REG_WR_DATA;
            chk("wr_en_with_ack_rise", 32'(RX_ACK && !ack_prev), 32'd1);
        end
        if (TX_REQ && !txreq_prev) txreq_rises++;
        if (RX_ACK && !ack_prev)   ack_rises++;
        if (TX_ERR)                err_cycles++;
        ack_prev   = RX_ACK;
        txreq_prev = TX_REQ;
    end

    function automatic logic sig(input int sel);
        case (sel)
            0:       return RX_ACK;
            1:       return TX_REQ;
            default: return TX_RESP_ACK;
        endcase
    endfunction

    task automatic wait_until(input int sel, input logic val, input string name);
        int n;
        n = 0;
        while (sig(sel) !== val && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (sig(sel) !== val) begin
            total++;
            bad++;
            $display("FAIL timeout_%s: got %b expected %b", name, sig(sel), val);
        end
    endtask

    task automatic rx_word(input logic [31:0] a, input logic [31:0] d,
                           input logic pend, input logic bcast, input logic fail);
        @(negedge CLK);
        RX_ADDR = a; RX_DATA = d; RX_PEND = pend; RX_BROADCAST = bcast; RX_FAIL = fail;
        RX_REQ = 1'b1;
        wait_until(0, 1'b1, "rx_ack");
        @(negedge CLK);
        chk("rx_ack_hold", 32'(RX_ACK), 32'd1);
        RX_REQ = 1'b0; RX_FAIL = 1'b0; RX_BROADCAST = 1'b0;
        @(negedge CLK);
        chk("rx_ack_drop", 32'(RX_ACK), 32'd0);
    endtask

    // Accepts reply words and checks each; fail_after>0 aborts after that word.
    task automatic serve_read(input logic [7:0] start, input int nwords,
                              input logic [31:0] exp_taddr, input int fail_after);
        logic [7:0] a;
        a = start;
        for (int k = 0; k < nwords; k++) begin
            wait_until(1, 1'b1, "tx_req");
            chk("tx_addr", TX_ADDR, exp_taddr);
            chk("tx_data", TX_DATA, {a, rom(a)});
            chk("tx_pend", 32'(TX_PEND), 32'(k != nwords - 1));
            TX_ACK = 1'b1;
            @(negedge CLK);
            wait_until(1, 1'b0, "tx_req_low");
            TX_ACK = 1'b0;
            a = a + 8'd1;
            if (fail_after == k + 1) begin
                TX_FAIL = 1'b1;
                break;
            end
        end
        if (fail_after == 0) begin
            repeat (2) @(negedge CLK);
            TX_SUCC = 1'b1;
        end
        wait_until(2, 1'b1, "resp_ack");
        @(negedge CLK);
        chk("resp_ack_hold", 32'(TX_RESP_ACK), 32'd1);
        TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        wait_until(2, 1'b0, "resp_ack_low");
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rx_ack"},   32'(RX_ACK),      32'd0);
        chk({tag, "_tx_req"},   32'(TX_REQ),      32'd0);
        chk({tag, "_tx_pend"},  32'(TX_PEND),     32'd0);
        chk({tag, "_tx_prio"},  32'(TX_PRIORITY), 32'd0);
        chk({tag, "_resp_ack"}, 32'(TX_RESP_ACK), 32'd0);
        chk({tag, "_wr_en"},    32'(REG_WR_EN),   32'd0);
        chk({tag, "_tx_err"},   32'(TX_ERR),      32'd0);
        chk({tag, "_msg_cnt"},  32'(MSG_CNT),     32'd0);
        chk({tag, "_tx_addr"},  TX_ADDR,          32'd0);
        chk({tag, "_tx_data"},  TX_DATA,          32'd0);
        chk({tag, "_wr_addr"},  32'(REG_WR_ADDR), 32'd0);
        chk({tag, "_wr_data"},  32'(REG_WR_DATA), 32'd0);
        chk({tag, "_rd_addr"},  32'(REG_RD_ADDR), 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        pend;
        logic        bcast;
        logic        exp_wr;
        logic [7:0]  exp_waddr;
        logic [23:0] exp_wdata;
        logic [7:0]  exp_cnt;
    } wvec_t;

    wvec_t tbl [9];

    initial begin
        int w0, t0, e0, a0;
        logic [7:0] exp_cnt;

        tbl[0] = '{32'h00000010, 32'h05ABCDEF, 1'b0, 1'b0, 1'b1, 8'h05, 24'hABCDEF, 8'd1};
        tbl[1] = '{32'h12345670, 32'hFF000001, 1'b0, 1'b0, 1'b1, 8'hFF, 24'h000001, 8'd2};
        tbl[2] = '{32'h00000000, 32'h10111111, 1'b1, 1'b0, 1'b1, 8'h10, 24'h111111, 8'd2};
        tbl[3] = '{32'h00000000, 32'h20222222, 1'b1, 1'b0, 1'b1, 8'h20, 24'h222222, 8'd2};
        tbl[4] = '{32'h00000000, 32'h30333333, 1'b0, 1'b0, 1'b1, 8'h30, 24'h333333, 8'd3};
        tbl[5] = '{32'h00000002, 32'h40444444, 1'b0, 1'b0, 1'b0, 8'h00, 24'h000000, 8'd3};
        tbl[6] = '{32'h00000000, 32'h50555555, 1'b0, 1'b1, 1'b0, 8'h00, 24'h000000, 8'd3};
        tbl[7] = '{32'h0000000F, 32'h60666666, 1'b1, 1'b0, 1'b0, 8'h00, 24'h000000, 8'd3};
        tbl[8] = '{32'h00000000, 32'h70777777, 1'b0, 1'b0, 1'b0, 8'h00, 24'h000000, 8'd3};

        repeat (3) @(negedge CLK);
        check_zero("init");
        RESET = 1'b0;

        // Write / ignore message table.
        for (int i = 0; i < 9; i++) begin
            w0 = wr_cnt;
            rx_word(tbl[i].addr, tbl[i].data, tbl[i].pend, tbl[i].bcast, 1'b0);
            @(negedge CLK);
            chk($sformatf("v%0d_wr_count", i), 32'(wr_cnt - w0), 32'(tbl[i].exp_wr));
            if (tbl[i].exp_wr) begin
                chk($sformatf("v%0d_wr_addr", i), 32'(last_waddr), 32'(tbl[i].exp_waddr));
                chk($sformatf("v%0d_wr_data", i), 32'(last_wdata), 32'(tbl[i].exp_wdata));
            end
            chk($sformatf("v%0d_msg_cnt", i), 32'(MSG_CNT), 32'(tbl[i].exp_cnt));
        end
        exp_cnt = 8'd3;

        // Two-word read-back starting at register 0x02.
        rx_word(32'h00000001, 32'h02011403, 1'b0, 1'b0, 1'b0);
        serve_read(8'h02, 2, 32'h00001403, 0);
        exp_cnt++;
        chk("rd2_msg_cnt", 32'(MSG_CNT), 32'(exp_cnt));

        // A write arriving during a reply waits until the reply completes.
        rx_word(32'h00000001, 32'h07000021, 1'b0, 1'b0, 1'b0);
        a0 = ack_rises;
        w0 = wr_cnt;
        RX_ADDR = 32'h00000010; RX_DATA = 32'h0A123456; RX_PEND = 1'b0; RX_REQ = 1'b1;
        serve_read(8'h07, 1, 32'h00000021, 0);
        exp_cnt++;
        chk("busy_no_ack", 32'(ack_rises - a0), 32'd0);
        wait_until(0, 1'b1, "late_ack");
        RX_REQ = 1'b0;
        wait_until(0, 1'b0, "late_ack_low");
        @(negedge CLK);
        exp_cnt++;
        chk("late_wr_count", 32'(wr_cnt - w0), 32'd1);
        chk("late_wr_addr", 32'(last_waddr), 32'h0A);
        chk("late_wr_data", 32'(last_wdata), 32'h123456);
        chk("late_msg_cnt", 32'(MSG_CNT), 32'(exp_cnt));

        // Register address wraps FF -> 00; extra read word is discarded.
        w0 = wr_cnt;
        rx_word(32'h00000001, 32'hFF012233, 1'b1, 1'b0, 1'b0);
        rx_word(32'h00000000, 32'h11223344, 1'b0, 1'b0, 1'b0);
        serve_read(8'hFF, 2, 32'h00002233, 0);
        exp_cnt++;
        chk("wrap_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("wrap_msg_cnt", 32'(MSG_CNT), 32'(exp_cnt));

        // TX_FAIL after the first of three words.
        rx_word(32'h00000001, 32'h10024455, 1'b0, 1'b0, 1'b0);
        t0 = txreq_rises;
        e0 = err_cycles;
        serve_read(8'h10, 3, 32'h00004455, 1);
        repeat (10) @(negedge CLK);
        chk("txfail_req_count", 32'(txreq_rises - t0), 32'd1);
        chk("txfail_err_cycles", 32'(err_cycles - e0), 32'd1);
        chk("txfail_msg_cnt", 32'(MSG_CNT), 32'(exp_cnt));

        // count-1 = FF gives 256 words.
        rx_word(32'h00000001, 32'h80FF5A07, 1'b0, 1'b0, 1'b0);
        t0 = txreq_rises;
        serve_read(8'h80, 256, 32'h00005A07, 0);
        exp_cnt++;
        chk("rd256_words", 32'(txreq_rises - t0), 32'd256);
        chk("rd256_msg_cnt", 32'(MSG_CNT), 32'(exp_cnt));

        // Write aborted on its third word keeps the first two writes.
        w0 = wr_cnt;
        rx_word(32'h00000000, 32'hA1000001, 1'b1, 1'b0, 1'b0);
        rx_word(32'h00000000, 32'hA2000002, 1'b1, 1'b0, 1'b0);
        rx_word(32'h00000000, 32'hA3000003, 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        chk("rxfail_wr_count", 32'(wr_cnt - w0), 32'd2);
        chk("rxfail_last_addr", 32'(last_waddr), 32'hA2);
        chk("rxfail_last_data", 32'(last_wdata), 32'h000002);
        chk("rxfail_msg_cnt", 32'(MSG_CNT), 32'(exp_cnt));
        // The next message is decoded afresh (function 2 is ignored).
        w0 = wr_cnt;
        rx_word(32'h00000002, 32'hC3000003, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("after_fail_ignored", 32'(wr_cnt - w0), 32'd0);

        // Reset in the middle of a reply word.
        rx_word(32'h00000001, 32'h40030102, 1'b0, 1'b0, 1'b0);
        wait_until(1, 1'b1, "tx_req_before_reset");
        RESET = 1'b1;
        @(negedge CLK);
        check_zero("midrst");
        RESET = 1'b0;
        repeat (3) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
